// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wr_arbiter
//  Purpose  : Shares the single regfile write port between in-order writeback
//             (WB) and a multi-cycle unit (MC). WB always wins the port; MC is
//             granted when WB is idle. A pending-destination scoreboard tracks
//             outstanding MC results so decode can stall on RAW/WAW hazards.
//             A starvation guard raises wb_hold after STARVE_MAX consecutive
//             MC losses so upstream freezes WB and MC can drain.
//  Ports    : clk, rst                      - clock / async active-high reset
//             wb_we, wb_waddr, wb_wdata     - WB write request
//             mc_issue, mc_issue_addr       - MC op accepted, marks dest pending
//             mc_valid, mc_waddr, mc_wdata  - MC result (held until mc_ready)
//             mc_ready                      - MC result written this cycle
//             rf_we, rf_waddr, rf_wdata     - regfile write port
//             chk_re1/2, chk_raddr1/2       - decode source operands
//             chk_dst_we, chk_dst           - decode destination
//             stall                         - decode hazard vs pending MC dest
//             wb_hold                       - registered WB freeze request
//             pend_cnt                      - number of pending registers
//             err                           - sticky protocol error
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              mc_issue,
    input  logic [ADDR_W-1:0] mc_issue_addr,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_waddr,
    input  logic [DATA_W-1:0] mc_wdata,
    output logic              mc_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              chk_re1,
    input  logic [ADDR_W-1:0] chk_raddr1,
    input  logic              chk_re2,
    input  logic [ADDR_W-1:0] chk_raddr2,
    input  logic              chk_dst_we,
    input  logic [ADDR_W-1:0] chk_dst,
    output logic              stall,
    output logic              wb_hold,
    output logic [ADDR_W:0]   pend_cnt,
    output logic              err
);

    localparam int c_NREG  = 1 << ADDR_W;
    localparam int c_CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE = c_CNT_W'(STARVE_MAX);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CONTEND = 2'd1;
    localparam logic [1:0] c_ST_FORCE   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic [c_NREG-1:0] r_pending;
    logic [c_NREG-1:0] w_pend_next;
    logic [ADDR_W:0]   r_pend_cnt;
    logic [ADDR_W:0]   w_pop;
    logic              r_wb_hold;
    logic              r_err;

    logic w_hs;
    logic w_hs_clr;
    logic w_issue_set;
    logic w_err_issue;
    logic w_err_hs;
    logic w_err_fsm;

    // ------------------------------------------------------------------------
    // Write-port mux: WB has absolute priority and is never back-pressured.
    // An MC result to r0 still completes its handshake but writes nothing.
    // ------------------------------------------------------------------------
    always_comb begin
        mc_ready = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (wb_we) begin
            rf_we    = 1'b1;
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
        end else if (mc_valid) begin
            mc_ready = 1'b1;
            rf_we    = (mc_waddr != '0);
            rf_waddr = mc_waddr;
            rf_wdata = mc_wdata;
        end
    end

    assign w_hs        = mc_valid & ~wb_we;
    assign w_hs_clr    = w_hs & (mc_waddr != '0);
    assign w_issue_set = mc_issue & (mc_issue_addr != '0);

    // ------------------------------------------------------------------------
    // Scoreboard next state. The set is applied after the clear so a new issue
    // to the register being retired this cycle leaves it pending.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pend_next = r_pending;
        if (w_hs_clr) begin
            w_pend_next[mc_waddr] = 1'b0;
        end
        if (w_issue_set) begin
            w_pend_next[mc_issue_addr] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < c_NREG; i++) begin
            w_pop = w_pop + {{ADDR_W{1'b0}}, w_pend_next[i]};
        end
    end

    // r0 is never marked pending, so no explicit r0 masking is needed here.
    assign stall = (chk_re1    & r_pending[chk_raddr1])
                 | (chk_re2    & r_pending[chk_raddr2])
                 | (chk_dst_we & r_pending[chk_dst]);

    // Re-issuing a destination is legal only when its previous result is
    // retiring in the same cycle.
    assign w_err_issue = w_issue_set & r_pending[mc_issue_addr]
                       & ~(w_hs_clr & (mc_waddr == mc_issue_addr));
    assign w_err_hs    = w_hs_clr & ~r_pending[mc_waddr];

    // ------------------------------------------------------------------------
    // Starvation FSM: counts consecutive cycles MC loses the port to WB.
    // ------------------------------------------------------------------------
    assign w_cnt_inc = r_cnt + c_ONE;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_err_fsm    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (mc_valid && wb_we) begin
                    w_cnt_next   = c_ONE;
                    w_state_next = (c_ONE == c_STARVE) ? c_ST_FORCE : c_ST_CONTEND;
                end
            end
            c_ST_CONTEND: begin
                if (!mc_valid) begin
                    w_state_next = c_ST_IDLE;
                    w_cnt_next   = '0;
                    w_err_fsm    = 1'b1;
                end else if (!wb_we) begin
                    w_state_next = c_ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc == c_STARVE) begin
                        w_state_next = c_ST_FORCE;
                    end
                end
            end
            c_ST_FORCE: begin
                // WB should be frozen here; if it still writes it wins anyway.
                if (wb_we) begin
                    w_err_fsm = 1'b1;
                end
                if (!mc_valid) begin
                    w_state_next = c_ST_IDLE;
                    w_cnt_next   = '0;
                    w_err_fsm    = 1'b1;
                end else if (!wb_we) begin
                    w_state_next = c_ST_IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_pending  <= '0;
            r_pend_cnt <= '0;
            r_wb_hold  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_pending  <= w_pend_next;
            r_pend_cnt <= w_pop;
            r_wb_hold  <= (w_state_next == c_ST_FORCE);
            r_err      <= r_err | w_err_issue | w_err_hs | w_err_fsm;
        end
    end

    assign pend_cnt = r_pend_cnt;
    assign wb_hold  = r_wb_hold;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wr_arbiter
//  Purpose  : Self-checking bench for regfile_wr_arbiter: table of write-mux
//             vectors, hand-written multi-cycle sequences, and a constrained
//             random run against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_we;
    logic [AW-1:0] wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic          mc_issue;
    logic [AW-1:0] mc_issue_addr;
    logic          mc_valid;
    logic [AW-1:0] mc_waddr;
    logic [DW-1:0] mc_wdata;
    logic          mc_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          chk_re1, chk_re2, chk_dst_we;
    logic [AW-1:0] chk_raddr1, chk_raddr2, chk_dst;
    logic          stall;
    logic          wb_hold;
    logic [AW:0]   pend_cnt;
    logic          err;

    int errors = 0;
    int checks = 0;

    regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .mc_issue(mc_issue), .mc_issue_addr(mc_issue_addr),
        .mc_valid(mc_valid), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata),
        .mc_ready(mc_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .chk_re1(chk_re1), .chk_raddr1(chk_raddr1),
        .chk_re2(chk_re2), .chk_raddr2(chk_raddr2),
        .chk_dst_we(chk_dst_we), .chk_dst(chk_dst),
        .stall(stall), .wb_hold(wb_hold), .pend_cnt(pend_cnt), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        wb_we = 0; wb_waddr = '0; wb_wdata = '0;
        mc_issue = 0; mc_issue_addr = '0;
        mc_valid = 0; mc_waddr = '0; mc_wdata = '0;
        chk_re1 = 0; chk_raddr1 = '0; chk_re2 = 0; chk_raddr2 = '0;
        chk_dst_we = 0; chk_dst = '0;
    endtask

    // ---------------- behavioural model ----------------
    bit mp[32];       // pending registers
    int streak;       // consecutive cycles the waiting MC result lost to WB
    bit merr;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mp[i] = 0;
        streak = 0;
        merr = 0;
    endtask

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += mp[i];
        return n;
    endfunction

    task automatic model_step();
        bit hs;
        hs = mc_valid && !wb_we;
        if (mc_issue && mc_issue_addr != 0 && mp[mc_issue_addr] && !(hs && mc_waddr == mc_issue_addr)) merr = 1;
        if (hs && mc_waddr != 0 && !mp[mc_waddr]) merr = 1;
        if (streak >= SM) begin
            if (wb_we) merr = 1;
            if (!mc_valid) begin merr = 1; streak = 0; end
            else if (hs) streak = 0;
        end else if (streak > 0) begin
            if (hs) streak = 0;
            else if (mc_valid) streak++;
            else begin merr = 1; streak = 0; end
        end else if (mc_valid && wb_we) begin
            streak = 1;
        end
        if (hs && mc_waddr != 0) mp[mc_waddr] = 0;
        if (mc_issue && mc_issue_addr != 0) mp[mc_issue_addr] = 1;
    endtask

    task automatic model_compare();
        bit e_ready, e_we, e_stall;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        e_ready = mc_valid && !wb_we;
        e_we    = wb_we || (mc_valid && mc_waddr != 0);
        e_addr  = wb_we ? wb_waddr : mc_waddr;
        e_data  = wb_we ? wb_wdata : mc_wdata;
        e_stall = (chk_re1 && mp[chk_raddr1]) || (chk_re2 && mp[chk_raddr2]) || (chk_dst_we && mp[chk_dst]);
        check("rnd_rf_we", rf_we, e_we);
        check("rnd_mc_ready", mc_ready, e_ready);
        if (e_we) begin
            check("rnd_rf_waddr", rf_waddr, e_addr);
            check("rnd_rf_wdata", rf_wdata, e_data);
        end
        check("rnd_stall", stall, e_stall);
        check("rnd_pend_cnt", pend_cnt, model_cnt());
        check("rnd_wb_hold", wb_hold, streak >= SM);
        check("rnd_err", err, merr);
    endtask

    // ---------------- write-mux vector table ----------------
    typedef struct {
        logic          wb_we;
        logic [AW-1:0] wb_waddr;
        logic [DW-1:0] wb_wdata;
        logic          mc_valid;
        logic [AW-1:0] mc_waddr;
        logic [DW-1:0] mc_wdata;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic          e_ready;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit mc_busy;
        logic [AW-1:0] cur_addr;
        logic [DW-1:0] cur_data;
        int start;

        vecs[0] = '{1'b1, 5'd3,  32'h0000_00A5, 1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  32'h0000_00A5, 1'b0};
        vecs[1] = '{1'b1, 5'd0,  32'h0000_1234, 1'b1, 5'd9,  32'h9999_9999, 1'b1, 5'd0,  32'h0000_1234, 1'b0};
        vecs[2] = '{1'b0, 5'd4,  32'h4444_4444, 1'b1, 5'd9,  32'hDEAD_BEEF, 1'b1, 5'd9,  32'hDEAD_BEEF, 1'b1};
        vecs[3] = '{1'b0, 5'd4,  32'h4444_4444, 1'b1, 5'd0,  32'hBEEF_0000, 1'b0, 5'd0,  32'h0,         1'b1};
        vecs[4] = '{1'b0, 5'd4,  32'h4444_4444, 1'b0, 5'd6,  32'h6666_6666, 1'b0, 5'd0,  32'h0,         1'b0};
        vecs[5] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'h0000_0001, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0};

        set_idle();
        rst = 1;
        repeat (2) @(negedge clk);

        // Mux is purely combinational; applying vectors under reset keeps
        // the sequential state untouched.
        foreach (vecs[i]) begin
            wb_we = vecs[i].wb_we; wb_waddr = vecs[i].wb_waddr; wb_wdata = vecs[i].wb_wdata;
            mc_valid = vecs[i].mc_valid; mc_waddr = vecs[i].mc_waddr; mc_wdata = vecs[i].mc_wdata;
            #1;
            check($sformatf("vec%0d_rf_we", i), rf_we, vecs[i].e_we);
            check($sformatf("vec%0d_mc_ready", i), mc_ready, vecs[i].e_ready);
            if (vecs[i].e_we) begin
                check($sformatf("vec%0d_rf_waddr", i), rf_waddr, vecs[i].e_addr);
                check($sformatf("vec%0d_rf_wdata", i), rf_wdata, vecs[i].e_data);
            end
            @(negedge clk);
        end

        // Reset state
        set_idle();
        chk_re1 = 1; chk_raddr1 = 5;
        #1;
        check("rst_stall", stall, 0);
        check("rst_pend_cnt", pend_cnt, 0);
        check("rst_wb_hold", wb_hold, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 0;
        set_idle();
        @(negedge clk);

        // Issue r5, hazard, then retire with WB idle
        mc_issue = 1; mc_issue_addr = 5;
        @(negedge clk);
        mc_issue = 0; chk_re1 = 1; chk_raddr1 = 5;
        #1;
        check("r5_stall", stall, 1);
        check("r5_pend_cnt", pend_cnt, 1);
        mc_valid = 1; mc_waddr = 5; mc_wdata = 32'h5555;
        #1;
        check("r5_mc_ready", mc_ready, 1);
        check("r5_rf_waddr", rf_waddr, 5);
        check("r5_rf_we", rf_we, 1);
        @(negedge clk);
        mc_valid = 0;
        #1;
        check("r5_stall_after", stall, 0);
        check("r5_pend_after", pend_cnt, 0);
        check("r5_err", err, 0);

        // Starvation: 4 lost cycles then FORCE
        set_idle();
        mc_issue = 1; mc_issue_addr = 6;
        @(negedge clk);
        set_idle();
        mc_valid = 1; mc_waddr = 6; mc_wdata = 32'h6666; wb_we = 1; wb_waddr = 1; wb_wdata = 32'h1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check($sformatf("starve_c%0d_hold", k), wb_hold, 0);
            check($sformatf("starve_c%0d_ready", k), mc_ready, 0);
            @(negedge clk);
        end
        #1;
        check("starve_c5_hold", wb_hold, 1);
        wb_we = 0;
        #1;
        check("starve_mc_ready", mc_ready, 1);
        check("starve_rf_waddr", rf_waddr, 6);
        @(negedge clk);
        mc_valid = 0;
        #1;
        check("starve_hold_release", wb_hold, 0);
        check("starve_err", err, 0);
        check("starve_pend", pend_cnt, 0);
        // FSM back in IDLE: a single contended cycle must not raise hold
        mc_issue = 1; mc_issue_addr = 8;
        @(negedge clk);
        mc_issue = 0; mc_valid = 1; mc_waddr = 8; wb_we = 1;
        @(negedge clk);
        wb_we = 0;
        #1;
        check("idle_again_hold", wb_hold, 0);
        @(negedge clk);
        set_idle();

        // r0 issue and result
        mc_issue = 1; mc_issue_addr = 0;
        @(negedge clk);
        mc_issue = 0;
        #1;
        check("r0_pend_cnt", pend_cnt, 0);
        mc_valid = 1; mc_waddr = 0;
        #1;
        check("r0_mc_ready", mc_ready, 1);
        check("r0_rf_we", rf_we, 0);
        @(negedge clk);
        mc_valid = 0;
        #1;
        check("r0_err", err, 0);

        // r7 re-issue while its previous result retires
        mc_issue = 1; mc_issue_addr = 7;
        @(negedge clk);
        mc_issue = 1; mc_issue_addr = 7; mc_valid = 1; mc_waddr = 7;
        #1;
        check("r7_pend_before", pend_cnt, 1);
        @(negedge clk);
        set_idle();
        chk_dst_we = 1; chk_dst = 7;
        #1;
        check("r7_pend_after", pend_cnt, 1);
        check("r7_stall", stall, 1);
        check("r7_err", err, 0);
        mc_valid = 1; mc_waddr = 7;
        @(negedge clk);
        // Handshake to a non-pending register flags an error
        set_idle();
        mc_valid = 1; mc_waddr = 12;
        @(negedge clk);
        set_idle();
        #1;
        check("nonpend_err", err, 1);

        // Reset while contending with r2, r9 pending
        mc_issue = 1; mc_issue_addr = 2;
        @(negedge clk);
        mc_issue_addr = 9;
        @(negedge clk);
        mc_issue = 0; mc_valid = 1; mc_waddr = 2; wb_we = 1;
        @(negedge clk);
        chk_re1 = 1; chk_raddr1 = 9;
        #1;
        check("mid_stall_pre", stall, 1);
        check("mid_pend_pre", pend_cnt, 2);
        rst = 1;
        #1;
        check("mid_rst_stall", stall, 0);
        check("mid_rst_pend", pend_cnt, 0);
        check("mid_rst_hold", wb_hold, 0);
        check("mid_rst_err", err, 0);

        // Constrained random run against the model
        @(negedge clk);
        set_idle();
        @(negedge clk);
        rst = 0;
        model_reset();
        mc_busy = 0; cur_addr = '0; cur_data = '0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (!mc_busy && model_cnt() > 0 && $urandom_range(0, 2) == 0) begin
                start = $urandom_range(0, 31);
                for (int j = 0; j < 32; j++) begin
                    if (!mc_busy && mp[(start + j) % 32]) begin
                        mc_busy = 1;
                        cur_addr = AW'((start + j) % 32);
                        cur_data = $urandom;
                    end
                end
            end
            mc_valid = mc_busy; mc_waddr = cur_addr; mc_wdata = cur_data;
            if (streak >= SM) wb_we = ($urandom_range(0, 9) == 0);
            else wb_we = ($urandom_range(0, 1) == 1);
            wb_waddr = AW'($urandom_range(0, 31)); wb_wdata = $urandom;
            mc_issue_addr = AW'($urandom_range(0, 7));
            mc_issue = ($urandom_range(0, 2) == 0) && (mc_issue_addr == 0 || !mp[mc_issue_addr]);
            chk_re1 = $urandom_range(0, 1) == 1; chk_raddr1 = AW'($urandom_range(0, 7));
            chk_re2 = $urandom_range(0, 1) == 1; chk_raddr2 = AW'($urandom_range(0, 7));
            chk_dst_we = $urandom_range(0, 1) == 1; chk_dst = AW'($urandom_range(0, 7));
            #1;
            model_compare();
            if (mc_valid && !wb_we) mc_busy = 0;
            model_step();
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
